// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg: shared types and constants for the multiply sequencing controller.
//   state_e          - controller state encoding
//   MUL_W / PROD_W   - operand and product widths
//   TIMEOUT_DEFAULT  - default watchdog limit in BUSY cycles
package mul_ctrl_pkg;

    localparam int unsigned MUL_W           = 32;
    localparam int unsigned PROD_W          = 64;
    localparam int unsigned TIMEOUT_DEFAULT = 40;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StDone  = 2'd2,
        StAbort = 2'd3
    } state_e;

endpackage

// File: rtl/mul_ctrl_if.sv
// mul_ctrl_if: bus between the multiply controller and the iterative multiplier.
//   mul_start_o   - run request to the multiplier (controller -> multiplier)
//   mul_sign_o    - 1 = signed multiply        (controller -> multiplier)
//   mul_op1_o     - latched operand A          (controller -> multiplier)
//   mul_op2_o     - latched operand B          (controller -> multiplier)
//   mul_result_i  - 64-bit product             (multiplier -> controller)
//   mul_ready_i   - product valid              (multiplier -> controller)
// Modports: master = controller side, slave = multiplier side.
interface mul_ctrl_if;
    import mul_ctrl_pkg::*;

    logic              mul_start_o;
    logic              mul_sign_o;
    logic [MUL_W-1:0]  mul_op1_o;
    logic [MUL_W-1:0]  mul_op2_o;
    logic [PROD_W-1:0] mul_result_i;
    logic              mul_ready_i;

    modport master (
        output mul_start_o,
        output mul_sign_o,
        output mul_op1_o,
        output mul_op2_o,
        input  mul_result_i,
        input  mul_ready_i
    );

    modport slave (
        input  mul_start_o,
        input  mul_sign_o,
        input  mul_op1_o,
        input  mul_op2_o,
        output mul_result_i,
        output mul_ready_i
    );

endinterface

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencing controller between EX and the iterative 32x32 multiplier.
// Accepts one mult/multu at a time, latches its operands, holds start and stalls the
// pipeline while the multiplier runs, then issues a one-cycle HI/LO write. A flush
// kills the operation; a watchdog aborts it and raises a sticky error.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   req_valid        - EX holds a multiply instruction
//   req_signed       - 1 = mult, 0 = multu
//   req_op_a/b       - rs / rt operands
//   flush            - kill the in-flight instruction
//   mul              - multiplier bus (master side)
//   stall_o          - freeze IF/ID/EX
//   hilo_we_o        - one-cycle HI/LO write enable
//   hi_o / lo_o      - product[63:32] / product[31:0]
//   timeout_err_o    - sticky watchdog error, cleared only by rst
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W          = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_signed,
    input  logic [MUL_W-1:0]  req_op_a,
    input  logic [MUL_W-1:0]  req_op_b,
    input  logic              flush,
    mul_ctrl_if.master        mul,
    output logic              stall_o,
    output logic              hilo_we_o,
    output logic [MUL_W-1:0]  hi_o,
    output logic [MUL_W-1:0]  lo_o,
    output logic              timeout_err_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [MUL_W-1:0]  op_a_q, op_a_d;
    logic [MUL_W-1:0]  op_b_q, op_b_d;
    logic              sign_q, sign_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PROD_W-1:0] result_q, result_d;
    logic              err_q, err_d;

    logic              start;
    logic              stall;
    logic              hilo_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        start    = 1'b0;
        stall    = 1'b0;
        hilo_we  = 1'b0;

        case (state_q)
            StIdle: begin
                // Stall already in the accept cycle so EX holds the instruction.
                if (req_valid && !flush) begin
                    stall   = 1'b1;
                    op_a_d  = req_op_a;
                    op_b_d  = req_op_b;
                    sign_d  = req_signed;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                start = 1'b1;
                stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (flush) begin
                    state_d = StAbort;
                end else if (mul.mul_ready_i) begin
                    result_d = mul.mul_result_i;
                    state_d  = StDone;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = StAbort;
                end
            end
            StDone: begin
                // Stall drops here so the EX instruction retires at the end of this cycle.
                hilo_we = !flush;
                state_d = StIdle;
            end
            StAbort: begin
                // One cycle with start low lets the multiplier clear its run flag.
                stall   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mul.mul_start_o = start;
    assign mul.mul_sign_o  = sign_q;
    assign mul.mul_op1_o   = op_a_q;
    assign mul.mul_op2_o   = op_b_q;

    assign stall_o       = stall;
    assign hilo_we_o     = hilo_we;
    assign hi_o          = result_q[PROD_W-1:MUL_W];
    assign lo_o          = result_q[MUL_W-1:0];
    assign timeout_err_o = err_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: self-checking bench for mul_ctrl. A transaction-level reference model
// predicts every output each cycle; directed scenarios add literal expectations.
module tb_mul_ctrl;

    localparam int unsigned TO = 40;

    function automatic logic [63:0] prod64(input logic s, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        return 64'(sa * sb);
    endfunction

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        req_valid  = 1'b0;
    logic        req_signed = 1'b0;
    logic [31:0] req_op_a   = '0;
    logic [31:0] req_op_b   = '0;
    logic        flush      = 1'b0;
    logic        rdy        = 1'b0;
    logic        stall, hilo_we, err;
    logic [31:0] hi, lo;

    mul_ctrl_if bus ();

    // Multiplier stand-in: real product only while ready, junk otherwise.
    assign bus.mul_ready_i  = rdy;
    assign bus.mul_result_i = rdy ? prod64(bus.mul_sign_o, bus.mul_op1_o, bus.mul_op2_o)
                                  : 64'hA5A5_5A5A_C3C3_3C3C;

    mul_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_signed    (req_signed),
        .req_op_a      (req_op_a),
        .req_op_b      (req_op_b),
        .flush         (flush),
        .mul           (bus),
        .stall_o       (stall),
        .hilo_we_o     (hilo_we),
        .hi_o          (hi),
        .lo_o          (lo),
        .timeout_err_o (err)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;
    int n_start = 0, n_we = 0, n_stall = 0;

    // Reference model: one operation in flight, a pending write or a recovery cycle.
    logic        m_in = 0, m_wr = 0, m_rec = 0, m_err = 0, m_sign = 0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [63:0] m_prod = '0;
    int          m_run = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic idle;
        idle = !m_in && !m_wr && !m_rec;
        chk("start",   64'(bus.mul_start_o), 64'(m_in));
        chk("sign",    64'(bus.mul_sign_o),  64'(m_sign));
        chk("op1",     64'(bus.mul_op1_o),   64'(m_a));
        chk("op2",     64'(bus.mul_op2_o),   64'(m_b));
        chk("stall",   64'(stall), 64'((idle && req_valid && !flush) || m_in || m_rec));
        chk("hilo_we", 64'(hilo_we), 64'(m_wr && !flush));
        chk("hi",      64'(hi), 64'(m_prod[63:32]));
        chk("lo",      64'(lo), 64'(m_prod[31:0]));
        chk("err",     64'(err), 64'(m_err));
        if (bus.mul_start_o === 1'b1) n_start++;
        if (hilo_we === 1'b1) n_we++;
        if (stall === 1'b1) n_stall++;
    endtask

    task automatic model_update();
        if (rst) begin
            m_in = 0; m_wr = 0; m_rec = 0; m_err = 0; m_sign = 0;
            m_a = '0; m_b = '0; m_prod = '0; m_run = 0;
        end else if (m_wr) begin
            m_wr = 0;
        end else if (m_rec) begin
            m_rec = 0;
        end else if (m_in) begin
            m_run++;
            if (flush) begin
                m_in = 0; m_rec = 1;
            end else if (rdy) begin
                m_prod = prod64(m_sign, m_a, m_b);
                m_in = 0; m_wr = 1;
            end else if (m_run == TO) begin
                m_err = 1; m_in = 0; m_rec = 1;
            end
        end else if (req_valid && !flush) begin
            m_in = 1; m_run = 0;
            m_a = req_op_a; m_b = req_op_b; m_sign = req_signed;
        end
    endtask

    // Check at the falling edge, advance the model at the rising edge, return just after.
    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Issue one request; BUSY cycles are numbered from 1. lat=0 means ready never rises.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int lat, input int hold, input int flush_at,
                          input int ncyc, input logic keep_req);
        req_valid = 1'b1; req_op_a = a; req_op_b = b; req_signed = s; flush = 1'b0;
        step();
        for (int i = 1; i <= ncyc; i++) begin
            if (keep_req) begin
                req_op_a = ~a; req_op_b = a ^ b ^ 32'h1357_9BDF; req_signed = ~s;
            end else begin
                req_valid = 1'b0;
            end
            flush = (i == flush_at);
            rdy   = (lat > 0 && i >= lat && i < lat + hold);
            step();
        end
        req_valid = 1'b0;
        flush     = 1'b0;
        rdy       = (lat > 0 && ncyc + 1 >= lat && ncyc + 1 < lat + hold);
    endtask

    int s0, w0, t0;

    initial begin
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_hilo",  64'({hi, lo}), 64'd0);
        chk("rst_err",   64'(err), 64'd0);

        // Signed -3 * 7, ready in the 33rd BUSY cycle, EX holds the instruction meanwhile.
        s0 = n_stall; w0 = n_we;
        run_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 33, 1, 0, 34, 1'b1);
        chk("signed_hi",    64'(hi), 64'hFFFF_FFFF);
        chk("signed_lo",    64'(lo), 64'hFFFF_FFEB);
        chk("signed_we",    64'(n_we - w0), 64'd1);
        chk("signed_stall", 64'(n_stall - s0), 64'd34);

        // Unsigned max * max with operands scrambled on the request ports during BUSY.
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 6, 1, 0, 7, 1'b1);
        chk("unsigned_hi",  64'(hi), 64'hFFFF_FFFE);
        chk("unsigned_lo",  64'(lo), 64'h0000_0001);
        chk("unsigned_op1", 64'(bus.mul_op1_o), 64'hFFFF_FFFF);

        // Flush in BUSY cycle 10: 10 start cycles, stall through ABORT, then IDLE.
        s0 = n_stall; w0 = n_we; t0 = n_start;
        run_op(32'h1234, 32'h5678, 1'b0, 0, 1, 10, 12, 1'b0);
        chk("flush_we",    64'(n_we - w0), 64'd0);
        chk("flush_start", 64'(n_start - t0), 64'd10);
        chk("flush_stall", 64'(n_stall - s0), 64'd12);

        // Flush together with ready: abort wins, result register untouched.
        w0 = n_we;
        run_op(32'd3, 32'd4, 1'b0, 5, 1, 5, 7, 1'b0);
        chk("flush_rdy_we", 64'(n_we - w0), 64'd0);
        chk("flush_rdy_lo", 64'(lo), 64'd1);

        // Flush in DONE suppresses the write only.
        w0 = n_we;
        run_op(32'd3, 32'd4, 1'b0, 3, 1, 4, 5, 1'b0);
        chk("flush_done_we", 64'(n_we - w0), 64'd0);
        chk("flush_done_lo", 64'(lo), 64'd12);

        // Ready held three cycles, then a back-to-back request at R+2.
        w0 = n_we;
        run_op(32'd9, 32'd9, 1'b0, 4, 3, 0, 5, 1'b0);
        chk("hold_we", 64'(n_we - w0), 64'd1);
        chk("hold_lo", 64'(lo), 64'd81);
        run_op(32'd5, 32'd6, 1'b0, 4, 1, 0, 5, 1'b0);
        chk("b2b_lo", 64'(lo), 64'd30);
        chk("b2b_we", 64'(n_we - w0), 64'd2);

        // Request with flush in IDLE is not accepted.
        s0 = n_stall; t0 = n_start;
        req_valid = 1'b1; flush = 1'b1;
        step();
        req_valid = 1'b0; flush = 1'b0;
        step();
        chk("idle_flush_start", 64'(n_start - t0), 64'd0);
        chk("idle_flush_stall", 64'(n_stall - s0), 64'd0);

        // Watchdog: ready never comes.
        s0 = n_stall; t0 = n_start;
        run_op(32'd2, 32'd3, 1'b1, 0, 1, 0, 42, 1'b0);
        chk("to_start", 64'(n_start - t0), 64'd40);
        chk("to_stall", 64'(n_stall - s0), 64'd42);
        chk("to_err",   64'(err), 64'd1);
        for (int i = 0; i < 5; i++) step();
        chk("to_sticky", 64'(err), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("to_rst_clear", 64'(err), 64'd0);
        step();

        // Reset in the middle of BUSY.
        req_valid = 1'b1; req_op_a = 32'd7; req_op_b = 32'd8; req_signed = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("mid_busy", 64'(bus.mul_start_o), 64'd1);
        rst = 1'b1;
        step();
        chk("mrst_start", 64'(bus.mul_start_o), 64'd0);
        chk("mrst_stall", 64'(stall), 64'd0);
        chk("mrst_ops",   64'({bus.mul_op1_o, bus.mul_op2_o}), 64'd0);
        chk("mrst_sign",  64'(bus.mul_sign_o), 64'd0);
        chk("mrst_hilo",  64'({hi, lo}), 64'd0);
        chk("mrst_we",    64'(hilo_we), 64'd0);
        rst = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
